// File: rtl/ss_reg_sequencer_pkg.sv
// Shared savestate definitions: header layout, magic word and
// the sequencer state encoding.
package ss_reg_sequencer_pkg;

    localparam int SS_IDX_W = 10;

    localparam logic [31:0] SS_MAGIC = 32'h4E45_5353;
    localparam int HDR_MAGIC_LSB = 32;
    localparam int HDR_CNT_LSB   = 0;
    localparam int HDR_CNT_W     = 16;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_HDR_WR,
        ST_RD_ADR,
        ST_RD_CAP,
        ST_MEM_WR,
        ST_HDR_RD,
        ST_MEM_RD,
        ST_REG_WR,
        ST_DONE
    } ss_seq_state_t;

    function automatic logic [63:0] ss_header(input int unsigned count);
        return {SS_MAGIC, 16'h0000, 16'(count)};
    endfunction

endpackage

// File: rtl/ss_reg_sequencer_mem_port.sv
// Registered single-outstanding memory request holder: request fields
// stay put until the ack is seen, read data is captured on the ack.
module ss_mem_port #(
    parameter int AW = 22
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          issue,
    input  logic          issue_we,
    input  logic [AW-1:0] issue_addr,
    input  logic [63:0]   issue_wdata,
    input  logic          mem_ack,
    input  logic [63:0]   mem_rdata,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [63:0]   mem_wdata,
    output logic          ack,
    output logic [63:0]   rdata
);

    logic          req_q, req_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [63:0]   wdata_q, wdata_d;
    logic [63:0]   rdata_q, rdata_d;

    assign ack = req_q && mem_ack;

    always_comb begin
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        if (issue && !req_q) begin
            req_d   = 1'b1;
            we_d    = issue_we;
            addr_d  = issue_addr;
            wdata_d = issue_wdata;
        end else if (ack) begin
            req_d   = 1'b0;
            rdata_d = mem_rdata;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    assign mem_req   = req_q;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign rdata     = rdata_q;

endmodule

// File: rtl/ss_reg_sequencer.sv
// Walks the savestate register bus, dumping every index to memory
// behind a header word on save and restoring it on load.
module ss_reg_sequencer
    import ss_reg_sequencer_pkg::*;
#(
    parameter int          NUM_REGS  = 64,
    parameter int          MEM_AW    = 22,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                save_start,
    input  logic                load_start,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [SS_IDX_W-1:0] ss_adr,
    output logic [63:0]         ss_din,
    output logic                ss_wren,
    input  logic [63:0]         ss_dout,
    output logic                mem_req,
    output logic                mem_we,
    output logic [MEM_AW-1:0]   mem_addr,
    output logic [63:0]         mem_wdata,
    input  logic [63:0]         mem_rdata,
    input  logic                mem_ack
);

    localparam logic [SS_IDX_W-1:0] LAST = SS_IDX_W'(NUM_REGS - 1);
    localparam logic [MEM_AW-1:0]   BASE = MEM_AW'(BASE_ADDR);
    localparam logic [63:0]         HDR  = ss_header(NUM_REGS);

    ss_seq_state_t       state_q, state_d;
    logic [SS_IDX_W-1:0] i_q, i_d;
    logic [SS_IDX_W-1:0] ss_adr_q, ss_adr_d;
    logic                ss_wren_q, ss_wren_d;
    logic                err_q, err_d;
    logic                busy_q, busy_d;
    logic [63:0]         data_q, data_d;

    logic                issue;
    logic                iss_we;
    logic [MEM_AW-1:0]   iss_addr;
    logic [63:0]         iss_wdata;
    logic                port_ack;
    logic [63:0]         port_rdata;
    logic [MEM_AW-1:0]   dat_addr;
    logic                hdr_ok;

    assign dat_addr = BASE + MEM_AW'(1) + MEM_AW'(i_q);

    assign hdr_ok =
        (mem_rdata[HDR_MAGIC_LSB +: 32] == SS_MAGIC) &&
        (mem_rdata[HDR_CNT_LSB +: HDR_CNT_W] == HDR_CNT_W'(NUM_REGS));

    always_comb begin
        state_d   = state_q;
        i_d       = i_q;
        ss_adr_d  = ss_adr_q;
        err_d     = err_q;
        data_d    = data_q;
        issue     = 1'b0;
        iss_we    = 1'b0;
        iss_addr  = BASE;
        iss_wdata = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (save_start) begin
                    state_d = ST_HDR_WR;
                    i_d     = '0;
                    err_d   = 1'b0;
                end else if (load_start) begin
                    state_d = ST_HDR_RD;
                    i_d     = '0;
                    err_d   = 1'b0;
                end
            end
            ST_HDR_WR: begin
                issue     = !mem_req;
                iss_we    = 1'b1;
                iss_wdata = HDR;
                if (port_ack) begin
                    state_d  = ST_RD_ADR;
                    ss_adr_d = i_q;
                end
            end
            ST_RD_ADR: state_d = ST_RD_CAP;
            ST_RD_CAP: begin
                data_d  = ss_dout;
                state_d = ST_MEM_WR;
            end
            ST_MEM_WR: begin
                issue     = !mem_req;
                iss_we    = 1'b1;
                iss_addr  = dat_addr;
                iss_wdata = data_q;
                if (port_ack) begin
                    if (i_q == LAST) begin
                        state_d = ST_DONE;
                    end else begin
                        i_d      = i_q + 1'b1;
                        ss_adr_d = i_q + 1'b1;
                        state_d  = ST_RD_ADR;
                    end
                end
            end
            ST_HDR_RD: begin
                issue = !mem_req;
                if (port_ack) begin
                    if (hdr_ok) begin
                        state_d = ST_MEM_RD;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end
                end
            end
            ST_MEM_RD: begin
                issue    = !mem_req;
                iss_addr = dat_addr;
                if (port_ack) begin
                    state_d  = ST_REG_WR;
                    ss_adr_d = i_q;
                end
            end
            ST_REG_WR: begin
                if (i_q == LAST) begin
                    state_d = ST_DONE;
                end else begin
                    i_d     = i_q + 1'b1;
                    state_d = ST_MEM_RD;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        ss_wren_d = (state_d == ST_REG_WR);
        // busy drops as DONE is entered so it never overlaps the pulse
        busy_d = (state_q != ST_IDLE) && (state_d != ST_IDLE) &&
                 (state_d != ST_DONE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            i_q       <= '0;
            ss_adr_q  <= '0;
            ss_wren_q <= 1'b0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
            data_q    <= '0;
        end else begin
            state_q   <= state_d;
            i_q       <= i_d;
            ss_adr_q  <= ss_adr_d;
            ss_wren_q <= ss_wren_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
            data_q    <= data_d;
        end
    end

    ss_mem_port #(
        .AW (MEM_AW)
    ) u_port (
        .clk         (clk),
        .reset_n     (reset_n),
        .issue       (issue),
        .issue_we    (iss_we),
        .issue_addr  (iss_addr),
        .issue_wdata (iss_wdata),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .ack         (port_ack),
        .rdata       (port_rdata)
    );

    assign busy    = busy_q;
    assign done    = (state_q == ST_DONE);
    assign err     = err_q;
    assign ss_adr  = ss_adr_q;
    assign ss_din  = port_rdata;
    assign ss_wren = ss_wren_q;

endmodule

// File: tb/tb_ss_reg_sequencer.sv
// Bench for ss_reg_sequencer: table vectors, random ops against a
// memory-image model, and hand-built start/reset corner cases.
module tb_ss_reg_sequencer;

    localparam int N  = 4;
    localparam int AW = 22;
    localparam logic [31:0] MAGIC = 32'h4E45_5353;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          save_start = 1'b0;
    logic          load_start = 1'b0;
    logic          busy, done, err, ss_wren;
    logic [9:0]    ss_adr;
    logic [63:0]   ss_din;
    logic [63:0]   ss_dout = '0;
    logic          mem_req, mem_we;
    logic [AW-1:0] mem_addr;
    logic [63:0]   mem_wdata;
    logic [63:0]   mem_rdata = '0;
    logic          mem_ack = 1'b0;

    always #5 clk = ~clk;

    ss_reg_sequencer #(
        .NUM_REGS  (N),
        .MEM_AW    (AW),
        .BASE_ADDR (0)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .save_start (save_start),
        .load_start (load_start),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .ss_adr     (ss_adr),
        .ss_din     (ss_din),
        .ss_wren    (ss_wren),
        .ss_dout    (ss_dout),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // register file behind the readback bus (registered, like the modules)
    logic [63:0] regval [N];
    always @(posedge clk)
        ss_dout <= (int'(ss_adr) < N) ? regval[int'(ss_adr[1:0])] : 64'd0;

    // memory and the model's view of what it should hold
    logic [63:0] mem [16];
    logic [63:0] img [N+1];

    function automatic logic [63:0] hdr_of(input int cnt);
        return {MAGIC, 16'h0000, 16'(cnt)};
    endfunction

    // memory responder with configurable ack delay and stability checks
    int            ack_delay = 0;
    int            rcnt = 0;
    logic          s_we;
    logic [AW-1:0] s_addr;
    logic [63:0]   s_wdata;
    int            req_cyc = 0;

    always @(negedge clk) begin
        if (!reset_n) begin
            mem_ack = 1'b0;
            rcnt = 0;
        end else if (mem_ack) begin
            mem_ack = 1'b0;
            rcnt = 0;
            chk("req_low_after_ack", {63'd0, mem_req}, 64'd0);
        end else if (mem_req) begin
            req_cyc++;
            if (rcnt == 0) begin
                s_we = mem_we;
                s_addr = mem_addr;
                s_wdata = mem_wdata;
                chk("addr_range", {63'd0, (mem_addr < 16)}, 64'd1);
            end else begin
                chk("hold_addr", 64'(mem_addr), 64'(s_addr));
                chk("hold_we", {63'd0, mem_we}, {63'd0, s_we});
                if (s_we) chk("hold_wdata", mem_wdata, s_wdata);
            end
            if (rcnt == ack_delay) begin
                mem_ack = 1'b1;
                if (mem_we) mem[mem_addr[3:0]] = mem_wdata;
                mem_rdata = mem[mem_addr[3:0]];
            end else begin
                rcnt++;
            end
        end
    end

    // observation of the register side and status outputs
    int          busy_cyc = 0;
    int          done_cnt = 0;
    int          wr_cnt = 0;
    logic [9:0]  wr_adr [$];
    logic [63:0] wr_din [$];

    always @(negedge clk) begin
        if (reset_n) begin
            if (busy) busy_cyc++;
            if (done) done_cnt++;
            if (ss_wren) begin
                wr_cnt++;
                wr_adr.push_back(ss_adr);
                wr_din.push_back(ss_din);
            end
        end
    end

    task automatic clr_obs();
        busy_cyc = 0;
        done_cnt = 0;
        wr_cnt = 0;
        req_cyc = 0;
        wr_adr.delete();
        wr_din.delete();
    endtask

    task automatic wait_done();
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 3000 && !seen; k++) begin
            @(negedge clk);
            seen = done;
        end
        if (!seen) chk("done_timeout", 64'd0, 64'd1);
        @(negedge clk);
    endtask

    task automatic run_op(input bit ld, input int d);
        ack_delay = d;
        @(negedge clk);
        clr_obs();
        if (ld) load_start = 1'b1;
        else save_start = 1'b1;
        @(negedge clk);
        save_start = 1'b0;
        load_start = 1'b0;
        wait_done();
    endtask

    function automatic bit hdr_good(input logic [63:0] h);
        return (h[63:32] == MAGIC) && (h[15:0] == 16'(N));
    endfunction

    // cost: header request (issue + 1+d), then per register
    // save = 2 bus cycles + issue + (1+d); load = issue + (1+d) + write
    function automatic int busy_exp(input bit ld, input bit ok, input int d);
        if (!ld) return (2 + d) + N * (4 + d) - 1;
        if (!ok) return (2 + d) - 1;
        return (2 + d) + N * (3 + d) - 1;
    endfunction

    task automatic model_save();
        img[0] = hdr_of(N);
        for (int i = 0; i < N; i++) img[i+1] = regval[i];
    endtask

    task automatic check_op(input string tag, input bit ld, input int d,
                            input bit exp_err, input int exp_nwr,
                            input int exp_busy);
        chk({tag, "_done"}, 64'(done_cnt), 64'd1);
        chk({tag, "_err"}, {63'd0, err}, {63'd0, exp_err});
        chk({tag, "_nwr"}, 64'(wr_cnt), 64'(exp_nwr));
        chk({tag, "_busy"}, 64'(busy_cyc), 64'(exp_busy));
        if (!ld) begin
            for (int i = 0; i <= N; i++)
                chk({tag, "_mem"}, mem[i], img[i]);
        end else if (wr_cnt == exp_nwr) begin
            for (int i = 0; i < exp_nwr; i++) begin
                chk({tag, "_wadr"}, 64'(wr_adr[i]), 64'(i));
                chk({tag, "_wdin"}, wr_din[i], img[i+1]);
            end
        end
        if (d < 0) chk({tag, "_delay"}, 64'd0, 64'd1);
    endtask

    typedef struct {
        bit          ld;
        int          d;
        bit          use_hdr;
        logic [63:0] hdr;
        bit          exp_err;
        int          exp_nwr;
        int          exp_busy;
    } vec_t;

    vec_t vecs [8];

    initial begin
        vecs[0] = '{1'b0, 0, 1'b0, 64'd0, 1'b0, 0, 17};
        vecs[1] = '{1'b1, 0, 1'b0, 64'd0, 1'b0, 4, 13};
        vecs[2] = '{1'b1, 0, 1'b1, 64'h4E45_5353_0000_0005, 1'b1, 0, 1};
        vecs[3] = '{1'b0, 0, 1'b0, 64'd0, 1'b0, 0, 17};
        vecs[4] = '{1'b1, 0, 1'b1, 64'h0000_0000_0000_0004, 1'b1, 0, 1};
        vecs[5] = '{1'b0, 7, 1'b0, 64'd0, 1'b0, 0, 52};
        vecs[6] = '{1'b1, 7, 1'b0, 64'd0, 1'b0, 4, 48};
        vecs[7] = '{1'b1, 7, 1'b1, 64'h4E45_5353_0000_0003, 1'b1, 0, 8};

        for (int i = 0; i < 16; i++) mem[i] = '0;
        for (int i = 0; i < N; i++) regval[i] = 64'h1111_0000_0000_0000 | 64'(i);

        #12;
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_err", {63'd0, err}, 64'd0);
        chk("rst_wren", {63'd0, ss_wren}, 64'd0);
        chk("rst_adr", 64'(ss_adr), 64'd0);
        chk("rst_din", ss_din, 64'd0);
        chk("rst_req", {63'd0, mem_req}, 64'd0);
        chk("rst_we", {63'd0, mem_we}, 64'd0);
        chk("rst_addr", 64'(mem_addr), 64'd0);
        chk("rst_wdata", mem_wdata, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int v = 0; v < 8; v++) begin
            if (!vecs[v].ld && v != 0)
                for (int i = 0; i < N; i++) regval[i] = {$urandom, $urandom};
            if (!vecs[v].ld) model_save();
            if (vecs[v].use_hdr) begin
                mem[0] = vecs[v].hdr;
                img[0] = vecs[v].hdr;
            end
            run_op(vecs[v].ld, vecs[v].d);
            check_op($sformatf("vec%0d", v), vecs[v].ld, vecs[v].d,
                     vecs[v].exp_err, vecs[v].exp_nwr, vecs[v].exp_busy);
        end

        for (int r = 0; r < 12; r++) begin
            bit ld;
            bit ok;
            int d;
            ld = 1'($urandom_range(0, 1));
            d = $urandom_range(0, 3);
            if (!ld) begin
                for (int i = 0; i < N; i++) regval[i] = {$urandom, $urandom};
                model_save();
            end else if ($urandom_range(0, 3) == 0) begin
                img[0] = {$urandom, $urandom};
                if ($urandom_range(0, 1) == 0) img[0] = hdr_of(N + 1);
                mem[0] = img[0];
            end
            ok = hdr_good(img[0]);
            run_op(ld, d);
            check_op($sformatf("rnd%0d", r), ld, d, ld && !ok,
                     (ld && ok) ? N : 0, busy_exp(ld, ok, d));
        end

        // both starts together: save wins; start latency; load ignored while busy
        ack_delay = 0;
        for (int i = 0; i < N; i++) regval[i] = {$urandom, $urandom};
        model_save();
        @(negedge clk);
        clr_obs();
        save_start = 1'b1;
        load_start = 1'b1;
        @(negedge clk);
        save_start = 1'b0;
        load_start = 1'b0;
        chk("lat_busy_n", {63'd0, busy}, 64'd0);
        chk("lat_req_n", {63'd0, mem_req}, 64'd0);
        @(negedge clk);
        chk("lat_busy_n1", {63'd0, busy}, 64'd1);
        chk("lat_req_n1", {63'd0, mem_req}, 64'd1);
        chk("lat_we_n1", {63'd0, mem_we}, 64'd1);
        chk("lat_addr_n1", 64'(mem_addr), 64'd0);
        repeat (4) @(negedge clk);
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
        wait_done();
        check_op("both", 1'b0, 0, 1'b0, 0, 17);
        clr_obs();
        repeat (10) @(negedge clk);
        chk("ignored_busy", 64'(busy_cyc), 64'd0);
        chk("ignored_req", 64'(req_cyc), 64'd0);

        // reset while writing register 2 of a load
        @(negedge clk);
        clr_obs();
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
        begin
            bit hit;
            hit = 1'b0;
            for (int k = 0; k < 200 && !hit; k++) begin
                @(negedge clk);
                hit = ss_wren && (ss_adr == 10'd2);
            end
            chk("reach_regwr2", {63'd0, hit}, 64'd1);
        end
        #2 reset_n = 1'b0;
        #1;
        chk("arst_busy", {63'd0, busy}, 64'd0);
        chk("arst_done", {63'd0, done}, 64'd0);
        chk("arst_err", {63'd0, err}, 64'd0);
        chk("arst_wren", {63'd0, ss_wren}, 64'd0);
        chk("arst_adr", 64'(ss_adr), 64'd0);
        chk("arst_din", ss_din, 64'd0);
        chk("arst_req", {63'd0, mem_req}, 64'd0);
        chk("arst_addr", 64'(mem_addr), 64'd0);
        chk("arst_wdata", mem_wdata, 64'd0);
        @(negedge clk);
        clr_obs();
        reset_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("post_rst_done", 64'(done_cnt), 64'd0);
        chk("post_rst_wren", 64'(wr_cnt), 64'd0);
        chk("post_rst_busy", 64'(busy_cyc), 64'd0);
        chk("post_rst_req", 64'(req_cyc), 64'd0);

        run_op(1'b1, 2);
        check_op("recover", 1'b1, 2, 1'b0, N, busy_exp(1'b1, 1'b1, 2));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
